// File: rtl/bit_serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package bit_serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // 2'd3 is unused; the FSM recovers from it to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_subtractor_one_bit.sv
// One-bit full-subtractor cell: diff = a ^ b ^ b_in, with borrow out.
module one_bit_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b - b_in, LSB first, WIDTH cycles).
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             sbrw_q, sbrw_d;
`endif

  logic cell_d, cell_bo;

  one_bit_subtractor u_cell (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .b_in  (brw_q),
    .diff  (cell_d),
    .b_out (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    sbrw_d   = sbrw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = b_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
        brw_d    = cell_bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_SUB_OVF_EN
          // Borrow entering the sign-bit cell, for the overflow test.
          sbrw_d  = brw_q;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      sbrw_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      sbrw_q   <= sbrw_d;
`endif
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign diff        = res_sh_q;
  assign b_out       = brw_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf         = sbrw_q ^ brw_q;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed + randomized self-checking bench for bit_serial_subtractor (WIDTH=8).
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_subtractor #(.WIDTH(W)) dut (
`ifdef SERIAL_SUB_OVF_EN
    .ovf         (ovf),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .b_in        (b_in),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .diff        (diff),
    .b_out       (b_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, check latency, optional DONE back-pressure, result and handshake.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input int hold, input bit poke);
    int n;
    logic [W-1:0] held_d;
    logic         held_b;
    chk("idle_start_ready", {31'b0, start_ready}, 32'd1);
    a = ta; b = tb; b_in = tbin; start_valid = 1'b1;
    tick();
    start_valid = poke;
    a = ~ta; b = ~tb; b_in = ~tbin;
    n = 0;
    while (!done_valid && n < 40) begin
      chk("run_start_ready", {31'b0, start_ready}, 32'd0);
      tick();
      n++;
    end
    chk("latency", n, W);
    chk("diff", {24'b0, diff}, {24'b0, ed});
    chk("b_out", {31'b0, b_out}, {31'b0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", {31'b0, ovf}, {31'b0, eo});
`else
    if (eo === 1'bx) $display("unexpected x ovf expectation");
`endif
    held_d = diff;
    held_b = b_out;
    done_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start_valid = poke ? ~start_valid : 1'b0;
      tick();
      chk("hold_done_valid", {31'b0, done_valid}, 32'd1);
      chk("hold_start_ready", {31'b0, start_ready}, 32'd0);
      chk("hold_diff", {24'b0, diff}, {24'b0, held_d});
      chk("hold_b_out", {31'b0, b_out}, {31'b0, held_b});
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("post_done_valid", {31'b0, done_valid}, 32'd0);
  endtask

  logic [W-1:0] ra, rb;
  logic         rbin;
  logic [W:0]   full;
  logic signed [W-1:0] sa, sb;
  int           sr;
  logic         eo_r;

  initial begin
    #3;
    chk("rst_start_ready", {31'b0, start_ready}, 32'd1);
    chk("rst_done_valid", {31'b0, done_valid}, 32'd0);
    chk("rst_diff", {24'b0, diff}, 32'd0);
    chk("rst_b_out", {31'b0, b_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
    do_op(8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0, 1'b0, 5, 1'b1);
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1, 1'b1);

    // Reset in the middle of RUN abandons the operation.
    a = 8'hC3; b = 8'h11; b_in = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("midrun_busy", {31'b0, start_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_start_ready", {31'b0, start_ready}, 32'd1);
    chk("mid_rst_done_valid", {31'b0, done_valid}, 32'd0);
    chk("mid_rst_diff", {24'b0, diff}, 32'd0);
    chk("mid_rst_b_out", {31'b0, b_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(8'h0A, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 500; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      sa = ra;
      sb = rb;
      sr = int'(sa) - int'(sb) - int'({31'b0, rbin});
      eo_r = (sr > 127) || (sr < -128);
      do_op(ra, rb, rbin, full[W-1:0], full[W], eo_r,
            int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
